// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Tags carry the source port in the top bit and a per-port read sequence below it.
package imem_pkg;

    localparam int unsigned TAG_W   = 9;
    localparam int unsigned SRC_BIT = 8;
    localparam int unsigned SEQ_W   = 8;

    typedef struct packed {
        logic [31:0]      addr;
        logic             write;
        logic [3:0]       wstrb;
        logic [31:0]      wdata;
        logic [TAG_W-1:0] tag;
    } imem_req_t;

    typedef enum logic {SlotEmpty, SlotFull} slot_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the two upstream request/response ports and the downstream memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface imem_arbiter_if;
    import imem_pkg::*;

    logic             p0_req, p0_ready, p0_write, p0_rvalid;
    logic [31:0]      p0_addr, p0_wdata, p0_rdata;
    logic [3:0]       p0_wstrb;
    logic [TAG_W-1:0] p0_rtag;

    logic             p1_req, p1_ready, p1_write, p1_rvalid;
    logic [31:0]      p1_addr, p1_wdata, p1_rdata;
    logic [3:0]       p1_wstrb;
    logic [TAG_W-1:0] p1_rtag;

    logic             mem_req, mem_ready, mem_write, mem_rvalid;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_wstrb;
    logic [TAG_W-1:0] mem_tag, mem_rtag;

    modport slave (
        input  p0_req, p0_addr, p0_write, p0_wstrb, p0_wdata,
        output p0_ready, p0_rdata, p0_rtag, p0_rvalid,
        input  p1_req, p1_addr, p1_write, p1_wstrb, p1_wdata,
        output p1_ready, p1_rdata, p1_rtag, p1_rvalid,
        output mem_req, mem_addr, mem_write, mem_wstrb, mem_wdata, mem_tag,
        input  mem_ready, mem_rdata, mem_rtag, mem_rvalid
    );

    modport master (
        output p0_req, p0_addr, p0_write, p0_wstrb, p0_wdata,
        input  p0_ready, p0_rdata, p0_rtag, p0_rvalid,
        output p1_req, p1_addr, p1_write, p1_wstrb, p1_wdata,
        input  p1_ready, p1_rdata, p1_rtag, p1_rvalid,
        input  mem_req, mem_addr, mem_write, mem_wstrb, mem_wdata, mem_tag,
        output mem_ready, mem_rdata, mem_rtag, mem_rvalid
    );

endinterface

// File: rtl/imem_rr_arb2.sv
// Two-way round-robin grant. On a tie the port not granted last wins; the
// last-grant pointer resets to 1 so port 0 takes the first tie.
module imem_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] eligible,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q, last_d;

    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one instruction-memory port between CPU fetch (port 0) and debug/loader (port 1):
// one-entry output slot, per-port read sequence tags and tag-routed responses.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic          clock,
    input  logic          reset,
    imem_arbiter_if.slave bus,
    output logic          err_spurious
);

    localparam int unsigned      OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    slot_state_e                 state_q, state_d;
    imem_req_t                   slot_q, slot_d, new_req;
    logic [1:0][SEQ_W-1:0]       seq_q, seq_d;
    logic [1:0][OUT_W-1:0]       out_q, out_d;
    logic                        err_q, err_d;
    logic [1:0]                  req, write, eligible, grant, rd_accept, rvalid;
    logic                        slot_free, accept, sel;

    assign req   = {bus.p1_req, bus.p0_req};
    assign write = {bus.p1_write, bus.p0_write};

    // Writes never wait on the read budget since they produce no response.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eligible[i] = req[i] && (write[i] || (out_q[i] < OUT_MAX));
        end
    end

    imem_rr_arb2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .eligible (eligible),
        .accept   (accept),
        .grant    (grant)
    );

    assign slot_free = (state_q == SlotEmpty) || bus.mem_ready;
    assign accept    = !reset && slot_free && (grant != 2'b00);
    assign sel       = grant[1];
    assign rd_accept = {2{accept}} & grant & ~write;

    always_comb begin
        new_req.addr  = sel ? bus.p1_addr  : bus.p0_addr;
        new_req.write = sel ? bus.p1_write : bus.p0_write;
        new_req.wstrb = sel ? bus.p1_wstrb : bus.p0_wstrb;
        new_req.wdata = sel ? bus.p1_wdata : bus.p0_wdata;
        new_req.tag   = {sel, seq_q[sel]};
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            SlotEmpty: if (accept) state_d = SlotFull;
            SlotFull:  if (!accept && bus.mem_ready) state_d = SlotEmpty;
            default:   state_d = SlotEmpty;
        endcase
        if (accept) begin
            slot_d = new_req;
        end
    end

    assign rvalid[0] = bus.mem_rvalid && !bus.mem_rtag[SRC_BIT] && (out_q[0] != '0);
    assign rvalid[1] = bus.mem_rvalid &&  bus.mem_rtag[SRC_BIT] && (out_q[1] != '0);

    always_comb begin
        seq_d = seq_q;
        out_d = out_q;
        for (int i = 0; i < 2; i++) begin
            if (rd_accept[i]) begin
                seq_d[i] = seq_q[i] + 1'b1;
            end
            if (rd_accept[i] && !rvalid[i]) begin
                out_d[i] = out_q[i] + 1'b1;
            end else if (!rd_accept[i] && rvalid[i]) begin
                out_d[i] = out_q[i] - 1'b1;
            end
        end
        err_d = err_q || (bus.mem_rvalid && (out_q[bus.mem_rtag[SRC_BIT]] == '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SlotEmpty;
            slot_q  <= '0;
            seq_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            seq_q   <= seq_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign bus.p0_ready  = accept && !sel;
    assign bus.p1_ready  = accept && sel;
    assign bus.p0_rvalid = rvalid[0];
    assign bus.p1_rvalid = rvalid[1];
    assign bus.p0_rdata  = bus.mem_rdata;
    assign bus.p1_rdata  = bus.mem_rdata;
    assign bus.p0_rtag   = bus.mem_rtag;
    assign bus.p1_rtag   = bus.mem_rtag;

    assign bus.mem_req   = (state_q == SlotFull);
    assign bus.mem_addr  = slot_q.addr;
    assign bus.mem_write = slot_q.write;
    assign bus.mem_wstrb = slot_q.wstrb;
    assign bus.mem_wdata = slot_q.wdata;
    assign bus.mem_tag   = slot_q.tag;

    assign err_spurious = err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: vector table plus directed sequences, with a cycle model
// and a scoreboard queue of expected downstream requests checked every cycle.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int unsigned MAX_OUT = 4;

    logic clock = 1'b0;
    logic reset;
    logic err_spurious;

    imem_arbiter_if bus ();

    imem_arbiter #(
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus.slave),
        .err_spurious (err_spurious)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic       m_last;
    logic [7:0] m_seq [2];
    int         m_out [2];
    logic       m_full;
    logic       m_err;
    imem_req_t  exp_q [$];

    typedef struct {
        logic        rst;
        logic        r0, w0, r1, w1, mrdy, mrv;
        logic [8:0]  rtag;
        logic [31:0] rdata;
        logic        e_rdy0, e_rdy1, e_mreq;
        logic [8:0]  e_tag;
        logic        e_rv0, e_rv1;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_seq[0] = '0;
        m_seq[1] = '0;
        m_out[0] = 0;
        m_out[1] = 0;
        m_full = 1'b0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    // Compare DUT against the model at the negedge, then advance the model one cycle.
    task automatic sample();
        logic [1:0] el, g;
        logic       free, acc, sel, drain, src;
        logic [1:0] rv;
        imem_req_t  r;
        @(negedge clock);
        el[0] = bus.p0_req && (bus.p0_write || m_out[0] < int'(MAX_OUT));
        el[1] = bus.p1_req && (bus.p1_write || m_out[1] < int'(MAX_OUT));
        free  = !m_full || bus.mem_ready;
        if (el[0] && el[1]) g = m_last ? 2'b01 : 2'b10;
        else g = el;
        if (reset) g = 2'b00;
        acc = free && (g != 2'b00);
        sel = g[1];
        check("p0_ready", bus.p0_ready, acc && !sel);
        check("p1_ready", bus.p1_ready, acc && sel);
        check("mem_req", bus.mem_req, m_full);
        check("err_spurious", err_spurious, m_err);
        if (m_full) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got mem_req with empty scoreboard, required entry");
            end else begin
                check("sb_addr", bus.mem_addr, exp_q[0].addr);
                check("sb_write", bus.mem_write, exp_q[0].write);
                check("sb_wstrb", bus.mem_wstrb, exp_q[0].wstrb);
                check("sb_wdata", bus.mem_wdata, exp_q[0].wdata);
                check("sb_tag", bus.mem_tag, exp_q[0].tag);
            end
        end
        src   = bus.mem_rtag[8];
        rv[0] = bus.mem_rvalid && !src && (m_out[0] != 0);
        rv[1] = bus.mem_rvalid && src && (m_out[1] != 0);
        check("p0_rvalid", bus.p0_rvalid, rv[0]);
        check("p1_rvalid", bus.p1_rvalid, rv[1]);
        if (bus.mem_rvalid) begin
            check("p0_rdata", bus.p0_rdata, bus.mem_rdata);
            check("p1_rtag", bus.p1_rtag, bus.mem_rtag);
        end
        drain = m_full && bus.mem_ready;
        if (reset) begin
            model_reset();
        end else begin
            if (bus.mem_rvalid && m_out[src] == 0) m_err = 1'b1;
            if (drain && exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) begin
                r.addr  = sel ? bus.p1_addr  : bus.p0_addr;
                r.write = sel ? bus.p1_write : bus.p0_write;
                r.wstrb = sel ? bus.p1_wstrb : bus.p0_wstrb;
                r.wdata = sel ? bus.p1_wdata : bus.p0_wdata;
                r.tag   = {sel, m_seq[sel]};
                exp_q.push_back(r);
                if (!r.write) begin
                    m_seq[sel] = m_seq[sel] + 8'd1;
                    m_out[sel] = m_out[sel] + 1;
                end
                m_last = sel;
            end
            if (rv[0]) m_out[0] = m_out[0] - 1;
            if (rv[1]) m_out[1] = m_out[1] - 1;
            m_full = acc || (m_full && !drain);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    task automatic idle_inputs();
        bus.p0_req = 0; bus.p0_write = 0; bus.p0_wstrb = 4'hF; bus.p0_addr = 32'h100;
        bus.p0_wdata = 32'h0;
        bus.p1_req = 0; bus.p1_write = 0; bus.p1_wstrb = 4'hF; bus.p1_addr = 32'h200;
        bus.p1_wdata = 32'h0;
        bus.mem_ready = 1; bus.mem_rvalid = 0; bus.mem_rtag = '0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    initial begin
        vecs[0] = '{0, 1,0,0,0, 1, 0, 9'h000, 32'h0,        1,0,0, 9'h000, 0,0};
        vecs[1] = '{0, 0,0,0,0, 1, 0, 9'h000, 32'h0,        0,0,1, 9'h000, 0,0};
        vecs[2] = '{0, 0,0,0,0, 1, 1, 9'h000, 32'hDEADBEEF, 0,0,0, 9'h000, 1,0};
        vecs[3] = '{1, 0,0,0,0, 1, 0, 9'h000, 32'h0,        0,0,0, 9'h000, 0,0};
        vecs[4] = '{0, 1,0,1,0, 1, 0, 9'h000, 32'h0,        1,0,0, 9'h000, 0,0};
        vecs[5] = '{0, 1,0,1,0, 1, 0, 9'h000, 32'h0,        0,1,1, 9'h000, 0,0};
        vecs[6] = '{0, 1,0,1,0, 1, 0, 9'h000, 32'h0,        1,0,1, 9'h100, 0,0};
        vecs[7] = '{0, 1,0,1,0, 1, 0, 9'h000, 32'h0,        0,1,1, 9'h001, 0,0};
        vecs[8] = '{0, 0,0,0,0, 1, 0, 9'h000, 32'h0,        0,0,1, 9'h101, 0,0};
        vecs[9] = '{0, 0,0,0,0, 1, 0, 9'h000, 32'h0,        0,0,0, 9'h000, 0,0};

        model_reset();
        idle_inputs();
        reset = 1;
        tick();
        step();
        reset = 0;

        // Single read, response routing, then round-robin alternation after reset.
        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst;
            bus.p0_req = vecs[i].r0; bus.p0_write = vecs[i].w0;
            bus.p1_req = vecs[i].r1; bus.p1_write = vecs[i].w1;
            bus.mem_ready = vecs[i].mrdy; bus.mem_rvalid = vecs[i].mrv;
            bus.mem_rtag = vecs[i].rtag; bus.mem_rdata = vecs[i].rdata;
            sample();
            check($sformatf("v%0d_p0_ready", i), bus.p0_ready, vecs[i].e_rdy0);
            check($sformatf("v%0d_p1_ready", i), bus.p1_ready, vecs[i].e_rdy1);
            check($sformatf("v%0d_mem_req", i), bus.mem_req, vecs[i].e_mreq);
            if (vecs[i].e_mreq) check($sformatf("v%0d_mem_tag", i), bus.mem_tag, vecs[i].e_tag);
            check($sformatf("v%0d_p0_rvalid", i), bus.p0_rvalid, vecs[i].e_rv0);
            check($sformatf("v%0d_p1_rvalid", i), bus.p1_rvalid, vecs[i].e_rv1);
            if (vecs[i].e_rv0) check($sformatf("v%0d_p0_rdata", i), bus.p0_rdata, vecs[i].rdata);
            tick();
        end
        reset = 0;

        // Outstanding limit: fifth read stalls until a response frees a credit.
        do_reset();
        bus.p0_req = 1; bus.p0_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            sample(); check("os_accept", bus.p0_ready, 1); tick();
        end
        sample(); check("os_stall", bus.p0_ready, 0); tick();
        bus.mem_rvalid = 1; bus.mem_rtag = 9'h000; bus.mem_rdata = 32'h1111;
        sample(); check("os_stall_resp", bus.p0_ready, 0); check("os_rvalid", bus.p0_rvalid, 1);
        tick();
        bus.mem_rvalid = 0;
        sample(); check("os_fifth", bus.p0_ready, 1); tick();
        bus.p0_req = 0;
        step();

        // Backpressure: slot held for 3 cycles, then drain and reload in one cycle.
        do_reset();
        bus.p0_req = 1; bus.p0_addr = 32'h500; bus.p1_req = 1; bus.p1_addr = 32'h600;
        bus.mem_ready = 0;
        sample(); check("bp_load", bus.p0_ready, 1); tick();
        bus.p0_req = 0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("bp_p0_ready", bus.p0_ready, 0);
            check("bp_p1_ready", bus.p1_ready, 0);
            check("bp_addr", bus.mem_addr, 32'h500);
            tick();
        end
        bus.mem_ready = 1;
        sample(); check("bp_reload", bus.p1_ready, 1); tick();
        bus.p1_req = 0;
        sample();
        check("bp_next_req", bus.mem_req, 1);
        check("bp_next_addr", bus.mem_addr, 32'h600);
        check("bp_next_tag", bus.mem_tag, 9'h100);
        tick();

        // Port 1 write: no seq advance, no outstanding; a response to it is spurious.
        do_reset();
        bus.p1_req = 1; bus.p1_write = 1; bus.p1_wstrb = 4'h3; bus.p1_addr = 32'h700;
        bus.p1_wdata = 32'hCAFE0001;
        step();
        bus.p1_req = 0;
        sample();
        check("wr_mem_write", bus.mem_write, 1);
        check("wr_wstrb", bus.mem_wstrb, 4'h3);
        check("wr_tag", bus.mem_tag, 9'h100);
        tick();
        bus.mem_rvalid = 1; bus.mem_rtag = 9'h100;
        sample(); check("wr_resp_dropped", bus.p1_rvalid, 0); tick();
        bus.mem_rvalid = 0;
        sample(); check("wr_err_set", err_spurious, 1); tick();
        bus.p1_req = 1; bus.p1_write = 0; bus.p1_wstrb = 4'hF;
        step();
        bus.p1_req = 0;
        sample(); check("wr_seq_unchanged", bus.mem_tag, 9'h100); tick();

        // Sequence wrap after 256 completed reads on port 0.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            bus.p0_req = 1; bus.p0_addr = 32'(k * 4);
            step();
            bus.p0_req = 0;
            step();
            bus.mem_rvalid = 1; bus.mem_rtag = {1'b0, 8'(k)};
            step();
            bus.mem_rvalid = 0;
        end
        bus.p0_req = 1; bus.p0_addr = 32'h800;
        step();
        bus.p0_req = 0;
        sample(); check("wrap_tag", bus.mem_tag, 9'h000); tick();

        // Reset while the slot is full discards it and zeroes the counters.
        bus.p0_req = 1; bus.mem_ready = 0;
        step();
        bus.p0_req = 0;
        sample(); check("rst_full_before", bus.mem_req, 1); tick();
        reset = 1;
        step();
        reset = 0;
        sample(); check("rst_mem_req", bus.mem_req, 0); tick();
        bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rtag = 9'h001;
        sample(); check("rst_resp_dropped", bus.p0_rvalid, 0); tick();
        bus.mem_rvalid = 0;
        sample(); check("rst_err_set", err_spurious, 1); tick();
        bus.p0_req = 1;
        step();
        bus.p0_req = 0;
        sample(); check("rst_seq_zero", bus.mem_tag, 9'h000); tick();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
